// File: rtl/snitch_hwpe_tcdm_adapter_if.sv
// HWPE req/gnt and TCDM reqrsp signal bundle for all adapter ports.
// slave = adapter side, master = HWPE plus TCDM environment side.
interface snitch_hwpe_tcdm_adapter_if #(
  parameter int unsigned NrPorts   = 16,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [NrPorts-1:0]                 hwpe_req_i;
  logic [NrPorts-1:0]                 hwpe_gnt_o;
  logic [NrPorts-1:0][AddrWidth-1:0]  hwpe_add_i;
  logic [NrPorts-1:0]                 hwpe_wen_i;
  logic [NrPorts-1:0][StrbWidth-1:0]  hwpe_be_i;
  logic [NrPorts-1:0][DataWidth-1:0]  hwpe_data_i;
  logic [NrPorts-1:0][DataWidth-1:0]  hwpe_r_data_o;
  logic [NrPorts-1:0]                 hwpe_r_valid_o;
  logic [NrPorts-1:0]                 tcdm_q_valid_o;
  logic [NrPorts-1:0]                 tcdm_q_ready_i;
  logic [NrPorts-1:0][AddrWidth-1:0]  tcdm_q_addr_o;
  logic [NrPorts-1:0]                 tcdm_q_write_o;
  logic [NrPorts-1:0][StrbWidth-1:0]  tcdm_q_strb_o;
  logic [NrPorts-1:0][DataWidth-1:0]  tcdm_q_data_o;
  logic [NrPorts-1:0]                 tcdm_p_valid_i;
  logic [NrPorts-1:0][DataWidth-1:0]  tcdm_p_data_i;

  modport slave (
    input  hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
    input  tcdm_q_ready_i, tcdm_p_valid_i, tcdm_p_data_i,
    output hwpe_gnt_o, hwpe_r_data_o, hwpe_r_valid_o,
    output tcdm_q_valid_o, tcdm_q_addr_o, tcdm_q_write_o, tcdm_q_strb_o, tcdm_q_data_o
  );

  modport master (
    output hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
    output tcdm_q_ready_i, tcdm_p_valid_i, tcdm_p_data_i,
    input  hwpe_gnt_o, hwpe_r_data_o, hwpe_r_valid_o,
    input  tcdm_q_valid_o, tcdm_q_addr_o, tcdm_q_write_o, tcdm_q_strb_o, tcdm_q_data_o
  );
endinterface

// File: rtl/snitch_hwpe_tcdm_adapter.sv
// Per-port HWPE req/gnt to TCDM reqrsp binder: combinational request path gated by a credit limit,
// read responses delivered one cycle after tcdm_p_valid_i; no HWPE-side response backpressure.
module snitch_hwpe_tcdm_adapter #(
  parameter int unsigned NrPorts        = 16,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          FilterWrRsp    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  snitch_hwpe_tcdm_adapter_if.slave bus,
  output logic                     busy_o,
  output logic [NrPorts-1:0]       err_o
);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic [NrPorts-1:0][CntWidth-1:0]       cnt_q, cnt_d;
  logic [NrPorts-1:0][MaxOutstanding-1:0] tag_q;
  logic [NrPorts-1:0][PtrWidth-1:0]       wr_ptr_q, rd_ptr_q;
  logic [NrPorts-1:0]                     rvalid_q;
  logic [NrPorts-1:0][DataWidth-1:0]      rdata_q;
  logic [NrPorts-1:0]                     err_q;
  logic                                   busy_q, busy_d;

  logic [NrPorts-1:0] can_issue, accept, rsp_hit, rsp_tag, fwd;

  // Request path is purely combinational; credit is the only gate.
  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      can_issue[p] = cnt_q[p] < MaxCnt;
    end
  end

  assign bus.tcdm_q_valid_o = bus.hwpe_req_i & can_issue;
  assign bus.hwpe_gnt_o     = bus.hwpe_req_i & can_issue & bus.tcdm_q_ready_i;
  assign bus.tcdm_q_addr_o  = bus.hwpe_add_i;
  assign bus.tcdm_q_strb_o  = bus.hwpe_be_i;
  assign bus.tcdm_q_data_o  = bus.hwpe_data_i;
  assign bus.tcdm_q_write_o = ~bus.hwpe_wen_i;

  always_comb begin
    accept  = '0;
    rsp_hit = '0;
    rsp_tag = '0;
    fwd     = '0;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    for (int p = 0; p < NrPorts; p++) begin
      accept[p]  = bus.tcdm_q_valid_o[p] & bus.tcdm_q_ready_i[p];
      // A response with nothing outstanding is an error, never a pop.
      rsp_hit[p] = bus.tcdm_p_valid_i[p] & (cnt_q[p] != '0);
      rsp_tag[p] = tag_q[p][rd_ptr_q[p]];
      fwd[p]     = rsp_hit[p] & (~rsp_tag[p] | ~FilterWrRsp);
      if (accept[p] && !rsp_hit[p]) begin
        cnt_d[p] = cnt_q[p] + CntWidth'(1);
      end else if (!accept[p] && rsp_hit[p]) begin
        cnt_d[p] = cnt_q[p] - CntWidth'(1);
      end
      busy_d = busy_d | (cnt_d[p] != '0) | fwd[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q    <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      for (int p = 0; p < NrPorts; p++) begin
        cnt_q[p]    <= cnt_d[p];
        rvalid_q[p] <= fwd[p];
        if (accept[p]) begin
          tag_q[p][wr_ptr_q[p]] <= ~bus.hwpe_wen_i[p];
          wr_ptr_q[p]           <= wr_ptr_q[p] + PtrWidth'(1);
        end
        if (rsp_hit[p]) begin
          rd_ptr_q[p] <= rd_ptr_q[p] + PtrWidth'(1);
        end
        if (fwd[p]) begin
          rdata_q[p] <= bus.tcdm_p_data_i[p];
        end
        if (bus.tcdm_p_valid_i[p] && !rsp_hit[p]) begin
          err_q[p] <= 1'b1;
        end
      end
    end
  end

  assign bus.hwpe_r_valid_o = rvalid_q;
  assign bus.hwpe_r_data_o  = rdata_q;
  assign busy_o             = busy_q;
  assign err_o              = err_q;
endmodule

// File: tb/tb_snitch_hwpe_tcdm_adapter.sv
// Directed bench for snitch_hwpe_tcdm_adapter with default parameters (16 ports, 4 credits, write filter on).
module tb_snitch_hwpe_tcdm_adapter;
  localparam int unsigned NrPorts   = 16;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               clear_i = 1'b0;
  logic               busy_o;
  logic [NrPorts-1:0] err_o;

  int checks = 0;
  int failures = 0;

  snitch_hwpe_tcdm_adapter_if #(.NrPorts(NrPorts), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus ();

  snitch_hwpe_tcdm_adapter #(
    .NrPorts(NrPorts), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
    .MaxOutstanding(4), .FilterWrRsp(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .bus(bus), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    bus.hwpe_req_i = '0; bus.hwpe_add_i = '0; bus.hwpe_wen_i = '1; bus.hwpe_be_i = '1;
    bus.hwpe_data_i = '0; bus.tcdm_q_ready_i = '1; bus.tcdm_p_valid_i = '0; bus.tcdm_p_data_i = '0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    checks++; if (bus.hwpe_r_valid_o !== '0) begin failures++; $display("FAIL rst_rvalid got=%h exp=0", bus.hwpe_r_valid_o); end
    checks++; if (bus.hwpe_r_data_o[0] !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.hwpe_r_data_o[0]); end
    checks++; if (err_o !== '0) begin failures++; $display("FAIL rst_err got=%h exp=0", err_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (bus.tcdm_q_valid_o !== '0) begin failures++; $display("FAIL rst_qvalid got=%h exp=0", bus.tcdm_q_valid_o); end
  endtask

  task automatic test_single_read();
    bus.hwpe_req_i[0] = 1'b1; bus.hwpe_wen_i[0] = 1'b1; bus.hwpe_add_i[0] = 32'h100;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL rd_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    checks++; if (bus.tcdm_q_addr_o[0] !== 32'h100) begin failures++; $display("FAIL rd_addr got=%h exp=100", bus.tcdm_q_addr_o[0]); end
    checks++; if (bus.tcdm_q_write_o[0] !== 1'b0) begin failures++; $display("FAIL rd_write got=%b exp=0", bus.tcdm_q_write_o[0]); end
    tick();
    bus.hwpe_req_i[0] = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rd_busy1 got=%b exp=1", busy_o); end
    tick();
    bus.tcdm_p_valid_i[0] = 1'b1; bus.tcdm_p_data_i[0] = 64'hDEADBEEF_00000001;
    #1;
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b0) begin failures++; $display("FAIL rd_early_rvalid got=%b exp=0", bus.hwpe_r_valid_o[0]); end
    tick();
    bus.tcdm_p_valid_i[0] = 1'b0;
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", bus.hwpe_r_valid_o[0]); end
    checks++; if (bus.hwpe_r_data_o[0] !== 64'hDEADBEEF_00000001) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef00000001", bus.hwpe_r_data_o[0]); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rd_busy2 got=%b exp=1", busy_o); end
    tick();
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", bus.hwpe_r_valid_o[0]); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rd_busy_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_write_read();
    bus.hwpe_req_i[0] = 1'b1; bus.hwpe_wen_i[0] = 1'b0; bus.hwpe_add_i[0] = 32'h200;
    bus.hwpe_data_i[0] = 64'h1111;
    #1;
    checks++; if (bus.tcdm_q_write_o[0] !== 1'b1) begin failures++; $display("FAIL wr_write got=%b exp=1", bus.tcdm_q_write_o[0]); end
    checks++; if (bus.tcdm_q_data_o[0] !== 64'h1111) begin failures++; $display("FAIL wr_data got=%h exp=1111", bus.tcdm_q_data_o[0]); end
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    tick();
    bus.hwpe_wen_i[0] = 1'b1; bus.hwpe_add_i[0] = 32'h208;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL wr_rd_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    tick();
    bus.hwpe_req_i[0] = 1'b0;
    bus.tcdm_p_valid_i[0] = 1'b1; bus.tcdm_p_data_i[0] = 64'hAAAA;
    tick();
    bus.tcdm_p_data_i[0] = 64'h5555_CAFE;
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b0) begin failures++; $display("FAIL wr_filtered got=%b exp=0", bus.hwpe_r_valid_o[0]); end
    checks++; if (bus.hwpe_r_data_o[0] !== 64'hDEADBEEF_00000001) begin failures++; $display("FAIL wr_hold got=%h exp=deadbeef00000001", bus.hwpe_r_data_o[0]); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy_o); end
    tick();
    bus.tcdm_p_valid_i[0] = 1'b0;
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b1) begin failures++; $display("FAIL wr_rd_rvalid got=%b exp=1", bus.hwpe_r_valid_o[0]); end
    checks++; if (bus.hwpe_r_data_o[0] !== 64'h5555_CAFE) begin failures++; $display("FAIL wr_rd_rdata got=%h exp=5555cafe", bus.hwpe_r_data_o[0]); end
    tick();
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b0) begin failures++; $display("FAIL wr_rd_pulse got=%b exp=0", bus.hwpe_r_valid_o[0]); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL wr_busy_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    bus.hwpe_req_i[0] = 1'b1; bus.hwpe_wen_i[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.hwpe_add_i[0] = 32'h400 + 32'(i * 8);
      #1;
      if (bus.hwpe_gnt_o[0] === 1'b1) grants++;
      if (i >= 4) begin
        checks++; if (bus.tcdm_q_valid_o[0] !== 1'b0 || bus.hwpe_gnt_o[0] !== 1'b0) begin
          failures++; $display("FAIL b2b_full_%0d got=%b%b exp=00", i, bus.tcdm_q_valid_o[0], bus.hwpe_gnt_o[0]);
        end
      end
      tick();
    end
    checks++; if (grants != 4) begin failures++; $display("FAIL b2b_grants got=%0d exp=4", grants); end
    // Full: a response alone frees a credit only from the next cycle.
    bus.tcdm_p_valid_i[0] = 1'b1; bus.tcdm_p_data_i[0] = 64'h0B0B_0001;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b0) begin failures++; $display("FAIL b2b_full_rsp_gnt got=%b exp=0", bus.hwpe_gnt_o[0]); end
    tick();
    bus.tcdm_p_data_i[0] = 64'h0B0B_0002;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL b2b_refill_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    checks++; if (bus.hwpe_r_data_o[0] !== 64'h0B0B_0001 || bus.hwpe_r_valid_o[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_rdata1 got=%b/%h exp=1/0b0b0001", bus.hwpe_r_valid_o[0], bus.hwpe_r_data_o[0]);
    end
    tick();
    bus.tcdm_p_valid_i[0] = 1'b0;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL b2b_cnt3_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    tick();
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b0) begin failures++; $display("FAIL b2b_cnt4_gnt got=%b exp=0", bus.hwpe_gnt_o[0]); end
    bus.hwpe_req_i[0] = 1'b0;
    bus.tcdm_p_valid_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.tcdm_p_data_i[0] = 64'hC0 + 64'(i);
      tick();
    end
    bus.tcdm_p_valid_i[0] = 1'b0;
    checks++; if (bus.hwpe_r_data_o[0] !== 64'hC3) begin failures++; $display("FAIL b2b_last_rdata got=%h exp=c3", bus.hwpe_r_data_o[0]); end
    tick();
    checks++; if (busy_o !== 1'b0 || err_o !== '0) begin failures++; $display("FAIL b2b_drain got=%b/%h exp=0/0", busy_o, err_o); end
  endtask

  task automatic test_ready_stall();
    bus.hwpe_req_i[0] = 1'b1; bus.hwpe_wen_i[0] = 1'b1; bus.hwpe_add_i[0] = 32'h300;
    bus.tcdm_q_ready_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.tcdm_q_valid_o[0] !== 1'b1 || bus.hwpe_gnt_o[0] !== 1'b0 || bus.tcdm_q_addr_o[0] !== 32'h300) begin
        failures++; $display("FAIL stall_%0d got=%b%b/%h exp=10/300", i, bus.tcdm_q_valid_o[0], bus.hwpe_gnt_o[0], bus.tcdm_q_addr_o[0]);
      end
      tick();
    end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stall_no_push got=%b exp=0", busy_o); end
    bus.tcdm_q_ready_i[0] = 1'b1;
    #1;
    checks++; if (bus.hwpe_gnt_o[0] !== 1'b1) begin failures++; $display("FAIL stall_gnt got=%b exp=1", bus.hwpe_gnt_o[0]); end
    tick();
    bus.hwpe_req_i[0] = 1'b0;
    bus.tcdm_p_valid_i[0] = 1'b1; bus.tcdm_p_data_i[0] = 64'h3300;
    tick();
    bus.tcdm_p_valid_i[0] = 1'b0;
    checks++; if (bus.hwpe_r_valid_o[0] !== 1'b1 || bus.hwpe_r_data_o[0] !== 64'h3300) begin
      failures++; $display("FAIL stall_rsp got=%b/%h exp=1/3300", bus.hwpe_r_valid_o[0], bus.hwpe_r_data_o[0]);
    end
    tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stall_single_tag got=%b exp=0", busy_o); end
  endtask

  task automatic test_unexpected();
    bus.tcdm_p_valid_i[5] = 1'b1; bus.tcdm_p_data_i[5] = 64'h5555;
    tick();
    bus.tcdm_p_valid_i[5] = 1'b0;
    checks++; if (err_o !== 16'h0020) begin failures++; $display("FAIL unexp_err got=%h exp=0020", err_o); end
    checks++; if (bus.hwpe_r_valid_o !== '0) begin failures++; $display("FAIL unexp_rvalid got=%h exp=0", bus.hwpe_r_valid_o); end
    tick(); tick();
    checks++; if (err_o !== 16'h0020 || busy_o !== 1'b0) begin failures++; $display("FAIL unexp_sticky got=%h/%b exp=0020/0", err_o, busy_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (err_o !== '0) begin failures++; $display("FAIL unexp_clear got=%h exp=0", err_o); end
  endtask

  task automatic test_clear_inflight();
    bus.hwpe_req_i[2] = 1'b1; bus.hwpe_wen_i[2] = 1'b1; bus.hwpe_add_i[2] = 32'h800;
    tick(); tick();
    bus.hwpe_req_i[2] = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL clr_busy_pre got=%b exp=1", busy_o); end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy_o); end
    bus.tcdm_p_valid_i[2] = 1'b1; bus.tcdm_p_data_i[2] = 64'h8888;
    tick(); tick();
    bus.tcdm_p_valid_i[2] = 1'b0;
    checks++; if (err_o !== 16'h0004) begin failures++; $display("FAIL clr_late_err got=%h exp=0004", err_o); end
    checks++; if (bus.hwpe_r_valid_o !== '0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL clr_late_rvalid got=%h/%b exp=0/0", bus.hwpe_r_valid_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_ready_stall();
    test_unexpected();
    test_clear_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
